efpga_tcdm_responder: RTL and testbench
=======================================

EFPGA_TCDM_RESPONDER -- requirements
Module: efpga_tcdm_responder

Interface
REQ-001 The block SHALL have the parameter DEPTH, default 256: number of 32-bit scratchpad words, power of two, range 4..1024.
REQ-002 The block SHALL have the parameter WAIT_CYCLES, default 0: extra response latency in cycles, range 0..15.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset. Clock and reset ports:
- clk_i, input, 1 bit: sole clock; all state changes on its rising edge.
- rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have the following request ports:
- tcdm_req_i, input, 1 bit: request from the eFPGA TCDM initiator port.
- tcdm_wen_i, input, 1 bit: 1 = read, 0 = write.
- tcdm_addr_i, input, 20 bits: byte address.
- tcdm_wdata_i, input, 32 bits: write data.
- tcdm_be_i, input, 4 bits: byte enables; bit n covers wdata[8n+7:8n].
REQ-005 The block SHALL have the following response and status ports:
- tcdm_gnt_o, output, 1 bit: request accepted this cycle.
- tcdm_valid_o, output, 1 bit: one-cycle response strobe.
- tcdm_rdata_o, output, 32 bits: read data, qualified by tcdm_valid_o.
- tcdm_fmo_o, output, 1 bit: error flag, qualified by tcdm_valid_o.
- err_cnt_o, output, 8 bits: saturating count of errored transactions.

Function
REQ-006 The block SHALL implement a three-state FSM with states IDLE, WAIT and RESP.
REQ-007 tcdm_gnt_o SHALL be combinational and equal tcdm_req_i AND (state == IDLE); it SHALL be 0 in WAIT and RESP.
REQ-008 On a grant cycle the block SHALL capture addr, wen, wdata and be.
REQ-009 On a grant cycle the FSM SHALL go to RESP if WAIT_CYCLES == 0; otherwise it SHALL go to WAIT with a 4-bit counter loaded with WAIT_CYCLES.
REQ-010 In WAIT the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the cycle the counter reads 1.
REQ-011 tcdm_valid_o SHALL be 1 exactly in RESP, for one cycle, exactly WAIT_CYCLES+1 cycles after the grant cycle.
REQ-012 After RESP the FSM SHALL return to IDLE; the earliest next grant is the cycle after RESP, so throughput is one transaction per WAIT_CYCLES+2 cycles.
REQ-013 A request SHALL be errored if the captured addr[1:0] != 0 or addr[19:2] >= DEPTH.
REQ-014 Address decode: word index SHALL be addr[log2(DEPTH)+1:2].
REQ-015 For a valid write, in the RESP cycle only the byte lanes with be = 1 SHALL be updated; be = 4'b0000 SHALL leave memory unchanged and still respond normally.
REQ-016 For a valid read, tcdm_rdata_o SHALL equal the addressed word in RESP, ignoring be.
REQ-017 A read following a write to the same word SHALL return the written data.
REQ-018 For an errored transaction: tcdm_fmo_o = 1 with valid, no memory write, tcdm_rdata_o = 0.
REQ-019 For an errored transaction err_cnt_o SHALL increment by 1 in RESP, saturating at 255 with no wrap.
REQ-020 When tcdm_valid_o = 0, tcdm_rdata_o and tcdm_fmo_o SHALL be 0.
REQ-021 Changes on the request inputs after the grant cycle SHALL NOT affect the pending transaction.
REQ-022 A request held high in WAIT or RESP SHALL be granted in the next IDLE cycle.

Reset
REQ-023 While rst_ni = 0 the block SHALL hold the FSM in IDLE, the counter at 0, all scratchpad words at 0, err_cnt_o at 0, and tcdm_valid_o, tcdm_rdata_o and tcdm_fmo_o at 0.
REQ-024 While rst_ni = 0, tcdm_gnt_o SHALL be 0 regardless of tcdm_req_i.
REQ-025 Reset asserted in WAIT or RESP SHALL drop the pending transaction: no valid pulse, and memory and err_cnt_o cleared.
REQ-026 The first grant after reset SHALL be possible in the first cycle after rst_ni deasserts.

Verification
REQ-027 With WAIT_CYCLES = 0: write 0xDEADBEEF to addr 0x10 (be = 4'hF), then read 0x10 -> gnt in the request cycle, valid one cycle later, rdata = 0xDEADBEEF, fmo = 0.
REQ-028 Partial write 0x11223344 to addr 0x10 with be = 4'b0101 over 0xDEADBEEF, then read -> rdata = 0xDE22BE44.
REQ-029 With WAIT_CYCLES = 3 and req held high continuously -> valid exactly 4 cycles after each grant, grants spaced 5 cycles apart, gnt = 0 in WAIT and RESP.
REQ-030 Error cases, with DEPTH = 256:
- read addr 0x00400 -> fmo = 1, rdata = 0, err_cnt_o = 1;
- write to addr 0x00002 -> fmo = 1, memory unchanged, err_cnt_o = 2.
REQ-031 260 errored transactions -> err_cnt_o = 255 with no wrap.
REQ-032 Reset in WAIT after a granted write to addr 0x0 -> no valid pulse; a subsequent read of 0x0 returns 0x00000000 with err_cnt_o = 0.

Source files
------------

// File: rtl/efpga_tcdm_responder.sv
// efpga_tcdm_responder: TCDM target with a byte-maskable scratchpad, fixed response latency and error counting
module efpga_tcdm_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tcdm_req_i,
  input  logic        tcdm_wen_i,
  input  logic [19:0] tcdm_addr_i,
  input  logic [31:0] tcdm_wdata_i,
  input  logic [3:0]  tcdm_be_i,
  output logic        tcdm_gnt_o,
  output logic        tcdm_valid_o,
  output logic [31:0] tcdm_rdata_o,
  output logic        tcdm_fmo_o,
  output logic [7:0]  err_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  state_e state_q, state_d;
  logic [19:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_wdata;
  logic [AW-1:0] idx;
  logic        err, we;
  assign tcdm_gnt_o = rst_ni & tcdm_req_i & (state_q == S_IDLE);
  assign idx        = addr_q[AW+1:2];
  assign err        = (addr_q[1:0] != 2'b00) | (addr_q[19:2] >= 18'(DEPTH));
  assign we         = (state_q == S_RESP) & ~wen_q & ~err;
  assign err_cnt_o  = err_cnt_q;
  // state, captured request, wait counter and error counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  // next state: grant leaves IDLE, the counter paces WAIT, RESP always returns to IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (tcdm_gnt_o) begin
        state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        cnt_d   = 4'(WAIT_CYCLES);
      end
      S_WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? S_RESP : S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // request capture on grant and saturating error count in RESP
  always_comb begin
    addr_d    = tcdm_gnt_o ? tcdm_addr_i  : addr_q;
    wen_d     = tcdm_gnt_o ? tcdm_wen_i   : wen_q;
    wdata_d   = tcdm_gnt_o ? tcdm_wdata_i : wdata_q;
    be_d      = tcdm_gnt_o ? tcdm_be_i    : be_q;
    err_cnt_d = (state_q == S_RESP && err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end
  // response outputs, forced to zero outside RESP
  always_comb begin
    tcdm_valid_o = state_q == S_RESP;
    tcdm_fmo_o   = tcdm_valid_o & err;
    tcdm_rdata_o = (tcdm_valid_o & ~err) ? mem_q[idx] : 32'h0;
  end
  // byte-lane merge of write data over the addressed word
  always_comb begin
    mem_wdata = mem_q[idx];
    for (int i = 0; i < 4; i++) mem_wdata[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_q[idx][8*i +: 8];
  end
  // scratchpad, cleared by reset and written only in RESP of a valid write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[idx] <= mem_wdata;
    end
  end
endmodule

// File: tb/tb_efpga_tcdm_responder.sv
// tb_efpga_tcdm_responder: randomized and directed checks of two responders (0 and 3 wait cycles) against a word-level model
module tb_efpga_tcdm_responder;
  logic clk = 1'b0, rst_ni = 1'b0, sel = 1'b0;
  logic req = 1'b0, wen = 1'b0;
  logic [19:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic gnt0, gnt3, val0, val3, fmo0, fmo3;
  logic [31:0] rd0, rd3;
  logic [7:0] ec0, ec3;
  logic gnt, valid, fmo;
  logic [31:0] rdata;
  logic [7:0] err_cnt;
  logic [31:0] mdl [2][256];
  int ec [2];
  int errors = 0, checks = 0, cyc = 0;
  logic [31:0] rd;
  int gq[$], vq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  efpga_tcdm_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u0 (
    .clk_i(clk), .rst_ni(rst_ni), .tcdm_req_i(req & ~sel), .tcdm_wen_i(wen), .tcdm_addr_i(addr),
    .tcdm_wdata_i(wdata), .tcdm_be_i(be), .tcdm_gnt_o(gnt0), .tcdm_valid_o(val0),
    .tcdm_rdata_o(rd0), .tcdm_fmo_o(fmo0), .err_cnt_o(ec0));
  efpga_tcdm_responder #(.DEPTH(256), .WAIT_CYCLES(3)) u3 (
    .clk_i(clk), .rst_ni(rst_ni), .tcdm_req_i(req & sel), .tcdm_wen_i(wen), .tcdm_addr_i(addr),
    .tcdm_wdata_i(wdata), .tcdm_be_i(be), .tcdm_gnt_o(gnt3), .tcdm_valid_o(val3),
    .tcdm_rdata_o(rd3), .tcdm_fmo_o(fmo3), .err_cnt_o(ec3));

  assign gnt     = sel ? gnt3 : gnt0;
  assign valid   = sel ? val3 : val0;
  assign fmo     = sel ? fmo3 : fmo0;
  assign rdata   = sel ? rd3  : rd0;
  assign err_cnt = sel ? ec3  : ec0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (sel=%0d t=%0t)", tag, got, exp, sel, $time);
    end
  endtask

  task automatic clear_model();
    for (int m = 0; m < 2; m++) begin
      ec[m] = 0;
      for (int i = 0; i < 256; i++) mdl[m][i] = '0;
    end
  endtask

  // one complete transaction on the selected responder, checked against the model
  task automatic txn(input logic w_en, input logic [19:0] a, input logic [31:0] wd, input logic [3:0] b, output logic [31:0] r);
    int w = sel ? 3 : 0;
    int m = sel ? 1 : 0;
    logic bad = (a[1:0] != 2'b00) || (a[19:2] >= 18'd256);
    logic [7:0] ix = a[9:2];
    r = '0;
    @(negedge clk);
    chk("idle_valid", 32'(valid), 32'd0);
    req = 1'b1; wen = w_en; addr = a; wdata = wd; be = b;
    #1 chk("gnt", 32'(gnt), 32'd1);
    @(posedge clk);
    #1 req = 1'($urandom); wen = 1'($urandom); addr = 20'($urandom); wdata = $urandom; be = 4'($urandom);
    for (int k = 1; k <= w + 1; k++) begin
      @(negedge clk);
      chk("busy_gnt", 32'(gnt), 32'd0);
      chk("valid", 32'(valid), 32'(k == w + 1));
      if (k == w + 1) begin
        r = rdata;
        chk("fmo", 32'(fmo), 32'(bad));
        if (bad || w_en) chk("rdata", rdata, bad ? 32'h0 : mdl[m][ix]);
      end
    end
    req = 1'b0;
    if (bad) ec[m] = (ec[m] < 255) ? ec[m] + 1 : 255;
    else if (!w_en) for (int i = 0; i < 4; i++) if (b[i]) mdl[m][ix][8*i +: 8] = wd[8*i +: 8];
    @(negedge clk);
    chk("after_valid", 32'(valid), 32'd0);
    chk("err_cnt", 32'(err_cnt), 32'(ec[m]));
  endtask

  initial begin
    clear_model();
    req = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1 chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_fmo", 32'(fmo), 32'd0);
      chk("rst_errcnt", 32'(err_cnt), 32'd0);
    end
    req = 1'b0; sel = 1'b0;
    rst_ni = 1'b1;
    // directed: full write, readback, partial write, error cases
    txn(1'b0, 20'h00010, 32'hDEADBEEF, 4'hF, rd);
    txn(1'b1, 20'h00010, 32'h0, 4'h0, rd);
    chk("rd_full", rd, 32'hDEADBEEF);
    txn(1'b0, 20'h00010, 32'h11223344, 4'b0101, rd);
    txn(1'b1, 20'h00010, 32'h0, 4'hF, rd);
    chk("rd_partial", rd, 32'hDE22BE44);
    txn(1'b0, 20'h00010, 32'hFFFFFFFF, 4'h0, rd);
    txn(1'b1, 20'h00010, 32'h0, 4'h0, rd);
    chk("rd_be0", rd, 32'hDE22BE44);
    txn(1'b1, 20'h00400, 32'h0, 4'hF, rd);
    chk("err1_cnt", 32'(err_cnt), 32'd1);
    txn(1'b0, 20'h00002, 32'h55555555, 4'hF, rd);
    chk("err2_cnt", 32'(err_cnt), 32'd2);
    txn(1'b1, 20'h00000, 32'h0, 4'hF, rd);
    chk("err2_mem", rd, 32'h0);
    txn(1'b0, 20'h003FC, 32'hA5A5C3C3, 4'hF, rd);
    txn(1'b1, 20'h003FC, 32'h0, 4'h0, rd);
    chk("rd_top", rd, 32'hA5A5C3C3);
    // held request on the 3-wait responder: grant/valid spacing
    sel = 1'b1;
    @(negedge clk);
    req = 1'b1; wen = 1'b1; addr = 20'h00010; be = 4'hF;
    for (int i = 0; i < 16; i++) begin
      #1 if (gnt) gq.push_back(cyc);
      if (valid) vq.push_back(cyc);
      @(negedge clk);
    end
    req = 1'b0;
    repeat (6) @(negedge clk);
    chk("held_grants", 32'(gq.size() >= 3), 32'd1);
    chk("held_valids", 32'(vq.size() >= 3), 32'd1);
    for (int i = 0; i + 1 < gq.size() && i < 3; i++) chk("gnt_spacing", 32'(gq[i+1] - gq[i]), 32'd5);
    for (int i = 0; i < vq.size() && i < gq.size() && i < 3; i++) chk("valid_lat", 32'(vq[i] - gq[i]), 32'd4);
    // randomized traffic on both responders
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int n = 0; n < 60; n++) begin
        int r = $urandom_range(0, 9);
        logic [19:0] a = (r < 7) ? 20'($urandom_range(0, 255)) << 2 : (r == 7) ? 20'($urandom_range(0, 1023)) | 20'd1 : 20'($urandom);
        txn(1'($urandom), a, $urandom, 4'($urandom), rd);
      end
    end
    // saturation of the error counter
    sel = 1'b0;
    for (int n = 0; n < 260; n++) txn(1'($urandom), 20'h00401 + 20'(n), $urandom, 4'hF, rd);
    chk("sat_cnt", 32'(err_cnt), 32'd255);
    // reset while a write waits on the 3-wait responder
    sel = 1'b1;
    @(negedge clk);
    req = 1'b1; wen = 1'b0; addr = 20'h0; wdata = 32'hCAFEF00D; be = 4'hF;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    rst_ni = 1'b0; req = 1'b1;
    clear_model();
    for (int i = 0; i < 5; i++) begin
      #1 chk("rstw_valid", 32'(valid), 32'd0);
      chk("rstw_gnt", 32'(gnt), 32'd0);
      @(negedge clk);
    end
    sel = 1'b0;
    #1 chk("rstw_cnt0", 32'(err_cnt), 32'd0);
    sel = 1'b1;
    req = 1'b0; wen = 1'b1;
    @(negedge clk);
    rst_ni = 1'b1; req = 1'b1;
    #1 chk("first_gnt", 32'(gnt), 32'd1);
    req = 1'b0;
    txn(1'b1, 20'h00000, 32'h0, 4'hF, rd);
    chk("rstw_rd", rd, 32'h0);
    chk("rstw_cnt", 32'(err_cnt), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
